// File: rtl/instruction_loader.sv
// Streams a program in as bytes, packs them MSB-first into 32-bit words and writes
// each word into the instruction memory while holding the CPU in reset.
module instruction_loader #(
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic [8:0]            WordCount,
   input  logic [7:0]            ByteIn,
   input  logic                  ByteValid,
   output logic                  ByteReady,
   output logic                  WriteEnable,
   output logic [ADDR_WIDTH-1:0] WriteAddress,
   output logic [31:0]           WriteData,
   output logic                  CpuHold,
   output logic                  Done,
   output logic                  Error
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RECV  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [8:0]  total_q, total_d;
   logic [8:0]  word_q, word_d;
   logic [1:0]  idx_q, idx_d;
   logic [31:0] data_q, data_d;
   logic        error_q, error_d;
   logic        ready_q, ready_d;
   logic        we_q, we_d;
   logic        hold_q, hold_d;
   logic        done_q, done_d;

   logic                  xfer_s;
   logic                  wc_zero_s;
   logic                  wc_big_s;
   logic [ADDR_WIDTH-1:0] addr_s;

   // ByteReady is registered and only high in RECV, so it doubles as the RECV qualifier.
   assign xfer_s    = ByteValid & ready_q;
   assign wc_zero_s = (WordCount == 9'd0);
   assign wc_big_s  = ({23'd0, WordCount} > 32'(DEPTH));

   // State and datapath registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         total_q <= 9'd0;
         word_q  <= 9'd0;
         idx_q   <= 2'd0;
         data_q  <= 32'd0;
         error_q <= 1'b0;
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         hold_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         total_q <= total_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         error_q <= error_d;
         ready_q <= ready_d;
         we_q    <= we_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
      end
   end

   // Next-state selection.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               if (wc_zero_s) begin
                  state_d = S_DONE;
               end else if (wc_big_s) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_RECV;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RECV: begin
            if (xfer_s && (idx_q == 2'd3)) begin
               state_d = S_WRITE;
            end else begin
               state_d = S_RECV;
            end
         end
         S_WRITE: begin
            if ((word_q + 9'd1) == total_q) begin
               state_d = S_DONE;
            end else begin
               state_d = S_RECV;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath updates and next values of the registered outputs.
   always_comb begin
      total_d = total_q;
      word_d  = word_q;
      idx_d   = idx_q;
      data_d  = data_q;
      error_d = error_q;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               if (wc_zero_s) begin
                  error_d = 1'b0;
               end else if (wc_big_s) begin
                  error_d = 1'b1;
               end else begin
                  error_d = 1'b0;
                  total_d = WordCount;
                  word_d  = 9'd0;
                  idx_d   = 2'd0;
               end
            end else begin
               error_d = error_q;
            end
         end
         S_RECV: begin
            if (xfer_s) begin
               idx_d = idx_q + 2'd1;
               case (idx_q)
                  2'd0:    data_d[31:24] = ByteIn;
                  2'd1:    data_d[23:16] = ByteIn;
                  2'd2:    data_d[15:8]  = ByteIn;
                  2'd3:    data_d[7:0]   = ByteIn;
                  default: data_d        = data_q;
               endcase
            end else begin
               idx_d = idx_q;
            end
         end
         S_WRITE: begin
            word_d = word_q + 9'd1;
            idx_d  = 2'd0;
         end
         S_DONE:  idx_d = 2'd0;
         default: idx_d = 2'd0;
      endcase

      ready_d = (state_d == S_RECV);
      we_d    = (state_d == S_WRITE);
      hold_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
   end

   // Word counter zero-extended into the memory address width.
   always_comb begin
      addr_s       = '0;
      addr_s[8:0]  = word_q;
   end

   assign ByteReady    = ready_q;
   assign WriteEnable  = we_q;
   assign WriteAddress = addr_s;
   assign WriteData    = data_q;
   assign CpuHold      = hold_q;
   assign Done         = done_q;
   assign Error        = error_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: expected writes are queued as bytes are
// driven and compared when WriteEnable is seen.
module tb_instruction_loader;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0;
   logic [8:0]  WordCount = 9'd0;
   logic [7:0]  ByteIn = 8'd0;
   logic        ByteValid = 1'b0;
   logic        ByteReady;
   logic        WriteEnable;
   logic [31:0] WriteAddress;
   logic [31:0] WriteData;
   logic        CpuHold;
   logic        Done;
   logic        Error;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          we_cnt = 0;
   int          done_cnt = 0;
   logic        prev_we = 1'b0;
   logic        done_prev_we = 1'b0;
   logic [63:0] sb_q [$];
   logic [31:0] wbuf [0:299];

   instruction_loader #(.DEPTH(256), .ADDR_WIDTH(32)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .WordCount(WordCount),
      .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(ByteReady),
      .WriteEnable(WriteEnable), .WriteAddress(WriteAddress), .WriteData(WriteData),
      .CpuHold(CpuHold), .Done(Done), .Error(Error)
   );

   always #5 Clk = ~Clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Output monitor on the falling edge: scoreboard pops and protocol checks.
   always @(negedge Clk) begin
      if (WriteEnable === 1'b1) begin
         we_cnt++;
         check_eq("ready_in_write", {63'd0, ByteReady}, 64'd0);
         if (sb_q.size() == 0) begin
            check_eq("unexpected_write", {32'd0, WriteAddress}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            logic [63:0] e;
            e = sb_q.pop_front();
            check_eq("write_addr", {32'd0, WriteAddress}, {32'd0, e[63:32]});
            check_eq("write_data", {32'd0, WriteData}, {32'd0, e[31:0]});
         end
      end
      if ((ByteReady === 1'b1) || (WriteEnable === 1'b1) || (Done === 1'b1)) begin
         check_eq("hold_active", {63'd0, CpuHold}, 64'd1);
      end
      if (Done === 1'b1) begin
         done_cnt++;
         done_prev_we = prev_we;
      end
      prev_we = (WriteEnable === 1'b1);
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic pulse_start(input logic [8:0] wc);
      Start     = 1'b1;
      WordCount = wc;
      step();
      Start     = 1'b0;
   endtask

   // Holds ByteValid with the byte until the edge that accepts it.
   task automatic send_byte(input logic [7:0] b);
      logic rdy;
      bit   ok;
      ok        = 1'b0;
      ByteIn    = b;
      ByteValid = 1'b1;
      for (int t = 0; t < 50; t++) begin
         rdy = ByteReady;
         step();
         if (rdy === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_eq("byte_timeout", 64'd0, 64'd1);
   endtask

   task automatic send_word(input int addr, input logic [31:0] w, input int gap);
      logic [7:0] bytes [4];
      bytes[0] = w[31:24];
      bytes[1] = w[23:16];
      bytes[2] = w[15:8];
      bytes[3] = w[7:0];
      for (int i = 0; i < 4; i++) begin
         if (i == 3) sb_q.push_back({addr[31:0], w});
         send_byte(bytes[i]);
         if (gap > 0) begin
            ByteValid = 1'b0;
            repeat (gap) step();
         end
      end
   endtask

   task automatic run_load(input int n, input int gap);
      int  we0;
      int  d0;
      bit  seen;
      we0  = we_cnt;
      d0   = done_cnt;
      seen = 1'b0;
      pulse_start(9'(n));
      @(negedge Clk);
      check_eq("hold_after_start", {63'd0, CpuHold}, 64'd1);
      check_eq("error_clear", {63'd0, Error}, 64'd0);
      for (int w = 0; w < n; w++) send_word(w, wbuf[w], gap);
      ByteValid = 1'b0;
      for (int t = 0; t < 20; t++) begin
         step();
         if (done_cnt != d0) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check_eq("done_timeout", 64'd0, 64'd1);
      check_eq("write_count", 64'(we_cnt - we0), 64'(n));
      check_eq("done_count", 64'(done_cnt - d0), 64'd1);
      check_eq("done_after_write", {63'd0, done_prev_we}, 64'd1);
      check_eq("hold_drop", {63'd0, CpuHold}, 64'd0);
      check_eq("done_low", {63'd0, Done}, 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq(tag, {ByteReady, WriteEnable, CpuHold, Done, Error, WriteAddress, WriteData},
               69'd0);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int we0;
      int d0;

      // Reset state
      Reset = 1'b1;
      repeat (2) step();
      check_all_zero("reset_state");
      Reset = 1'b0;
      step();

      // Two words, continuous stream
      wbuf[0] = 32'h2009_0001;
      wbuf[1] = 32'h200A_0007;
      run_load(2, 0);

      // Same program with ByteValid gaps
      run_load(2, 2);

      // Empty program
      we0 = we_cnt;
      d0  = done_cnt;
      pulse_start(9'd0);
      @(negedge Clk);
      check_eq("wc0_done", {63'd0, Done}, 64'd1);
      check_eq("wc0_ready", {63'd0, ByteReady}, 64'd0);
      step();
      check_eq("wc0_done_low", {63'd0, Done}, 64'd0);
      check_eq("wc0_writes", 64'(we_cnt - we0), 64'd0);
      check_eq("wc0_done_count", 64'(done_cnt - d0), 64'd1);

      // Oversized request is rejected and stays in IDLE
      pulse_start(9'd257);
      @(negedge Clk);
      check_eq("big_error", {63'd0, Error}, 64'd1);
      check_eq("big_hold", {63'd0, CpuHold}, 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         check_eq("big_ready", {63'd0, ByteReady}, 64'd0);
      end
      check_eq("big_error_sticky", {63'd0, Error}, 64'd1);
      step();
      wbuf[0] = 32'hDEAD_BEEF;
      run_load(1, 0);

      // Full-depth load, data equals the word index
      for (int i = 0; i < 256; i++) wbuf[i] = 32'(i);
      run_load(256, 0);

      // Reset in the middle of a 3-word load
      we0 = we_cnt;
      pulse_start(9'd3);
      send_word(0, 32'h1122_3344, 0);
      send_byte(8'h55);
      ByteValid = 1'b0;
      pulse_start(9'd257);
      @(negedge Clk);
      check_eq("midload_start_error", {63'd0, Error}, 64'd0);
      check_eq("midload_start_ready", {63'd0, ByteReady}, 64'd1);
      send_byte(8'h66);
      ByteValid = 1'b0;
      Reset     = 1'b1;
      step();
      check_all_zero("abort_reset_state");
      step();
      Reset = 1'b0;
      repeat (6) step();
      check_eq("abort_writes", 64'(we_cnt - we0), 64'd1);
      check_eq("abort_hold", {63'd0, CpuHold}, 64'd0);

      check_eq("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
